// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_IBE  = 2'b10
  } fetch_exc_e;

  localparam logic [2:0]  KSEG0 = 3'b100;
  localparam logic [2:0]  KSEG1 = 3'b101;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - memory fetch bus and decode handoff interfaces
interface fetch_mem_if;
  logic        req;
  logic [31:0] addr;
  logic        uncached;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, uncached, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, uncached, output gnt, rvalid, rdata, err);
endinterface

interface fetch_inst_if;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [1:0]  exc;

  modport master (output valid, inst, pc, exc, input ready);
  modport slave  (input valid, inst, pc, exc, output ready);
endinterface

// File: rtl/fetch_xlat.sv
// rtl/fetch_xlat.sv - kseg0/kseg1 virtual-to-physical decode with fetch address error
module fetch_xlat
  import fetch_pkg::*;
(
  input  logic [31:0] va,
  output logic [31:0] paddr,
  output logic        uncached,
  output logic        adel
);

  logic [2:0] seg;

  assign seg      = va[31:29];
  assign paddr    = {3'b000, va[28:0]};
  assign uncached = (seg == KSEG1);
  assign adel     = !((seg == KSEG0) || (seg == KSEG1)) || (va[1:0] != 2'b00);

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch FSM: translation, one-outstanding memory fetch, decode handoff
module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [31:0]  pc_q,
  output logic [31:0]  pc_d,
  output logic         pc_e,
  input  logic         redir_valid,
  input  logic [31:0]  redir_pc,
  fetch_mem_if.master  mem,
  fetch_inst_if.master dec
);

  fetch_state_e state_q, state_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  fetch_exc_e   inst_exc_q, inst_exc_d;

  logic [31:0]  paddr;
  logic         uncached;
  logic         adel;
  logic         unused_reset_vec;

  assign unused_reset_vec = ^RESET_VEC;

  fetch_xlat u_xlat (
    .va       (pc_q),
    .paddr    (paddr),
    .uncached (uncached),
    .adel     (adel)
  );

  assign mem.addr     = paddr;
  assign mem.uncached = uncached;

  assign dec.valid = inst_valid_q;
  assign dec.inst  = inst_q;
  assign dec.pc    = inst_pc_q;
  assign dec.exc   = inst_exc_q;

  always_comb begin
    state_d      = state_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_exc_d   = inst_exc_q;
    mem.req      = 1'b0;
    pc_e         = 1'b0;
    pc_d         = '0;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        mem.req = !adel;
        if (redir_valid) begin
          // a grant in the redirect cycle leaves a response in flight
          state_d = (!adel && mem.gnt) ? ST_DRAIN : ST_REQ;
        end else if (adel) begin
          inst_valid_d = 1'b1;
          inst_d       = '0;
          inst_pc_d    = pc_q;
          inst_exc_d   = EXC_ADEL;
          state_d      = ST_HOLD;
        end else if (mem.gnt) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redir_valid) begin
          state_d = mem.rvalid ? ST_REQ : ST_DRAIN;
        end else if (mem.rvalid) begin
          inst_valid_d = 1'b1;
          inst_pc_d    = pc_q;
          if (mem.err) begin
            inst_d     = '0;
            inst_exc_d = EXC_IBE;
          end else begin
            inst_d     = mem.rdata;
            inst_exc_d = EXC_NONE;
          end
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redir_valid || dec.ready) begin
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
        if (!redir_valid && dec.ready) begin
          pc_e = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end

      ST_DRAIN: begin
        if (mem.rvalid) state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase

    // redirect overrides any sequential advance chosen above
    if (redir_valid && (state_q != ST_IDLE)) begin
      pc_e = 1'b1;
      pc_d = redir_pc;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_exc_q   <= EXC_NONE;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_exc_q   <= inst_exc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch with a handoff scoreboard
module tb_if_fetch;

  logic        clk;
  logic        clrn;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_e;
  logic        redir_valid;
  logic [31:0] redir_pc;

  fetch_mem_if  mem_bus ();
  fetch_inst_if dec_bus ();

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb[$];

  if_fetch #(.RESET_VEC(32'h8000_0000)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .pc_q        (pc_q),
    .pc_d        (pc_d),
    .pc_e        (pc_e),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .mem         (mem_bus),
    .dec         (dec_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // the bench plays the PC register: it loads pc_d on an edge where pc_e was high
  task automatic cyc();
    logic        e;
    logic [31:0] d;
    #1;
    e = pc_e;
    d = pc_d;
    @(posedge clk);
    #1;
    if (e) pc_q = d;
  endtask

  task automatic hold_phase(input int rw);
    exp_t e;
    #1;
    for (int i = 0; i < rw; i++) begin
      chkb("hold_valid", dec_bus.valid, 1'b1);
      chkb("hold_no_pce", pc_e, 1'b0);
      chk("hold_inst", dec_bus.inst, sb[0].inst);
      chk("hold_pc", dec_bus.pc, sb[0].pc);
      chk("hold_exc", 32'(dec_bus.exc), 32'(sb[0].exc));
      cyc();
      #1;
    end
    dec_bus.ready = 1'b1;
    #1;
    chkb("hand_valid", dec_bus.valid, 1'b1);
    chkb("hand_pce", pc_e, 1'b1);
    chk("hand_pcd", pc_d, pc_q + 32'd4);
    e = sb.pop_front();
    chk("sb_inst", dec_bus.inst, e.inst);
    chk("sb_pc", dec_bus.pc, e.pc);
    chk("sb_exc", 32'(dec_bus.exc), 32'(e.exc));
    cyc();
    dec_bus.ready = 1'b0;
  endtask

  task automatic req_phase(input int gw);
    logic [31:0] a;
    logic        u;
    a = {3'b000, pc_q[28:0]};
    u = (pc_q[31:29] == 3'b101);
    #1;
    chkb("req_valid_low", dec_bus.valid, 1'b0);
    for (int i = 0; i < gw; i++) begin
      chkb("req_wait_req", mem_bus.req, 1'b1);
      chk("req_wait_addr", mem_bus.addr, a);
      cyc();
      #1;
    end
    chkb("mem_req", mem_bus.req, 1'b1);
    chk("mem_addr", mem_bus.addr, a);
    chkb("mem_uncached", mem_bus.uncached, u);
    mem_bus.gnt = 1'b1;
    cyc();
    mem_bus.gnt = 1'b0;
  endtask

  task automatic resp_phase(input logic [31:0] data, input logic err, input int rw);
    #1;
    chkb("wait_valid_low", dec_bus.valid, 1'b0);
    chkb("wait_no_req", mem_bus.req, 1'b0);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = data;
    mem_bus.err    = err;
    sb.push_back('{err ? 32'h0 : data, pc_q, err ? 2'b10 : 2'b00});
    cyc();
    mem_bus.rvalid = 1'b0;
    mem_bus.err    = 1'b0;
    hold_phase(rw);
  endtask

  task automatic adel_phase();
    #1;
    chkb("adel_no_req", mem_bus.req, 1'b0);
    sb.push_back('{32'h0, pc_q, 2'b01});
    cyc();
    hold_phase(0);
  endtask

  initial begin
    clrn           = 1'b0;
    pc_q           = 32'h8000_0000;
    redir_valid    = 1'b0;
    redir_pc       = '0;
    mem_bus.gnt    = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;
    mem_bus.err    = 1'b0;
    dec_bus.ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chkb("rst_valid", dec_bus.valid, 1'b0);
    chk("rst_inst", dec_bus.inst, 32'h0);
    chk("rst_inst_pc", dec_bus.pc, 32'h0);
    chk("rst_exc", 32'(dec_bus.exc), 32'h0);
    chkb("rst_req", mem_bus.req, 1'b0);
    chkb("rst_pce", pc_e, 1'b0);
    chk("rst_pcd", pc_d, 32'h0);

    clrn = 1'b1;
    #1;
    chkb("idle_no_req", mem_bus.req, 1'b0);
    chkb("idle_no_pce", pc_e, 1'b0);
    cyc();

    // zero-wait sequential fetches from the reset vector
    req_phase(0);
    resp_phase(32'h2408_0001, 1'b0, 0);
    chk("seq_pc", pc_q, 32'h8000_0004);
    req_phase(0);
    resp_phase(32'h2409_0002, 1'b0, 0);

    // kseg1 with delayed grant
    pc_q = 32'hBFC0_0000;
    #1;
    chk("kseg1_addr", mem_bus.addr, 32'h1FC0_0000);
    req_phase(3);
    resp_phase(32'h3C1C_0001, 1'b0, 0);

    // address errors: unmapped segment, then misaligned
    pc_q = 32'h0040_0000;
    adel_phase();
    pc_q = 32'h8000_0002;
    adel_phase();

    // bus error held four cycles before acceptance
    pc_q = 32'h8000_0010;
    req_phase(1);
    resp_phase(32'hFFFF_FFFF, 1'b1, 4);

    // redirect while waiting for the response
    req_phase(0);
    redir_valid = 1'b1;
    redir_pc    = 32'h8000_0100;
    #1;
    chkb("redir_wait_pce", pc_e, 1'b1);
    chk("redir_wait_pcd", pc_d, 32'h8000_0100);
    cyc();
    redir_valid = 1'b0;
    #1;
    chkb("drain_no_req", mem_bus.req, 1'b0);
    chkb("drain_valid", dec_bus.valid, 1'b0);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hDEAD_BEEF;
    cyc();
    mem_bus.rvalid = 1'b0;
    #1;
    chk("redir_addr", mem_bus.addr, 32'h0000_0100);
    req_phase(0);
    resp_phase(32'h0000_0100, 1'b0, 0);

    // redirect and ready together in HOLD drop the held instruction
    req_phase(0);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'h1234_5678;
    cyc();
    mem_bus.rvalid = 1'b0;
    redir_valid    = 1'b1;
    redir_pc       = 32'h8000_0200;
    dec_bus.ready  = 1'b1;
    #1;
    chkb("redir_hold_valid", dec_bus.valid, 1'b1);
    chkb("redir_hold_pce", pc_e, 1'b1);
    chk("redir_hold_pcd", pc_d, 32'h8000_0200);
    cyc();
    redir_valid   = 1'b0;
    dec_bus.ready = 1'b0;
    #1;
    chkb("drop_valid", dec_bus.valid, 1'b0);
    chk("redir2_addr", mem_bus.addr, 32'h0000_0200);
    req_phase(0);
    resp_phase(32'h0BAD_F00D, 1'b0, 0);

    // asynchronous reset while an instruction is held
    req_phase(0);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = 32'hCAFE_0001;
    cyc();
    mem_bus.rvalid = 1'b0;
    #1;
    chkb("pre_rst_valid", dec_bus.valid, 1'b1);
    clrn = 1'b0;
    #1;
    chkb("arst_valid", dec_bus.valid, 1'b0);
    chkb("arst_req", mem_bus.req, 1'b0);
    chk("arst_inst", dec_bus.inst, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
